// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over imem req/ack
// into a 2-entry queue whose head drives the IF/ID register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                head is held (not consumed) while high
//   redirect_valid       one-cycle PC redirect pulse
//   redirect_target      redirect PC (bits [1:0] forced to 0)
//   imem_req/imem_addr   fetch request and address to instruction memory
//   imem_ack/imem_rdata  fetch completion and returned word
//   if_valid             queue head valid
//   if_instr             head instruction (0 when empty)
//   if_pc_plus4          head fetch address + 4 (0 when empty)
//   if_pc                next PC to be requested
module if_fetch_unit #(
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] req_addr, req_addr_next;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] push_pc4;
    logic [1:0]        count, count_next;
    logic              head, head_next;
    logic              tail;
    logic              pop, push, space, req_c;

    logic [31:0]       q_instr [2];
    logic [ADDR_W-1:0] q_pc4   [2];

    logic              unused_bits;
    assign unused_bits = ^redirect_target[1:0];

    assign target = {redirect_target[ADDR_W-1:2], 2'b00};

    assign if_valid    = (count != 2'd0);
    assign if_instr    = if_valid ? q_instr[head] : 32'h0;
    assign if_pc_plus4 = if_valid ? q_pc4[head] : '0;
    assign if_pc       = pc;

    assign pop   = if_valid && !stall;
    // A slot is free once this cycle's pop is accounted for.
    assign space = (count != 2'd2) || pop;
    // With count 1 the tail is the other slot; with 0 or 2 it is the head.
    assign tail  = head ^ count[0];

    // Memory must tolerate req dropping while rst is held.
    assign imem_req = req_c && !rst;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        req_c         = 1'b0;
        imem_addr     = req_addr;
        push          = 1'b0;
        push_pc4      = req_addr + ADDR_W'(4);
        unique case (state)
            IDLE: begin
                imem_addr = pc;
                push_pc4  = pc + ADDR_W'(4);
                if (space && !redirect_valid) begin
                    req_c         = 1'b1;
                    req_addr_next = pc;
                    if (imem_ack) begin
                        // Zero-wait memory completes in the issue cycle.
                        push    = 1'b1;
                        pc_next = push_pc4;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    state_next = IDLE;
                    if (!redirect_valid) begin
                        push    = 1'b1;
                        pc_next = push_pc4;
                    end
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (redirect_valid) begin
            pc_next = target;
            push    = 1'b0;
        end
    end

    always_comb begin
        head_next  = head;
        count_next = count;
        if (redirect_valid) begin
            count_next = 2'd0;
        end else begin
            head_next  = head ^ pop;
            count_next = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            req_addr <= RESET_VECTOR;
            count    <= 2'd0;
            head     <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
            head     <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_instr[tail] <= imem_rdata;
            q_pc4[tail]   <= push_pc4;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a behavioural memory with
// per-request latency feeds an expected-instruction queue.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    sb_t         sb[$];
    logic        outst;
    logic        taint;
    logic [31:0] o_addr;
    int          o_age;
    int          o_lat;
    int          lat_cfg;
    logic [31:0] exp_fetch;
    int          cyc;
    int          first_valid;
    int          n_pop;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc_plus4     (if_pc_plus4),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        outst       = 1'b0;
        taint       = 1'b0;
        o_age       = 0;
        o_lat       = 0;
        exp_fetch   = 32'h0;
        cyc         = 0;
        first_valid = 0;
        n_pop       = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        model_reset();
    endtask

    task automatic tick(input logic st, input logic rv, input logic [31:0] rt);
        logic pop_m;
        logic space_m;
        sb_t  e;
        @(negedge clk);
        rst             = 1'b0;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        #1;
        cyc++;
        pop_m   = (sb.size() != 0) && !st;
        space_m = (sb.size() < 2) || pop_m;
        check("valid", 32'(if_valid), 32'(sb.size() != 0));
        if (if_valid && first_valid == 0) first_valid = cyc;
        if (sb.size() == 0) begin
            check("nop_instr", if_instr, 32'h0);
            check("nop_pc4", if_pc_plus4, 32'h0);
        end
        if (!outst) begin
            check("req_issue", 32'(imem_req), 32'(space_m && !rv));
            if (imem_req) begin
                check("req_addr", imem_addr, exp_fetch);
                outst  = 1'b1;
                taint  = 1'b0;
                o_addr = imem_addr;
                o_age  = 0;
                o_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            end
        end else begin
            check("req_hold", 32'(imem_req), 32'h1);
            check("addr_hold", imem_addr, o_addr);
        end
        if (outst && o_age >= o_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = o_addr ^ KEY;
        end
        if (pop_m && !rv) begin
            e = sb.pop_front();
            check("instr", if_instr, e.instr);
            check("pc4", if_pc_plus4, e.pc4);
            n_pop++;
        end
        if (rv) begin
            sb.delete();
            exp_fetch = rt & ~32'h3;
            if (imem_ack) outst = 1'b0;
            else if (outst) taint = 1'b1;
        end else if (imem_ack) begin
            if (!taint) begin
                e.instr = o_addr ^ KEY;
                e.pc4   = o_addr + 32'h4;
                sb.push_back(e);
                exp_fetch = o_addr + 32'h4;
            end
            outst = 1'b0;
        end
        if (outst) o_age++;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        lat_cfg         = 0;
        model_reset();

        // zero-wait streaming
        do_reset();
        lat_cfg = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);
        check("first_valid", 32'(first_valid), 32'd2);
        check("tput", 32'(n_pop), 32'd9);

        // stall saturates the queue
        do_reset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h0);
        check("full_req", 32'(imem_req), 32'h0);
        check("full_head", if_pc_plus4, 32'h8);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0);

        // redirect during a slow fetch
        do_reset();
        lat_cfg = 3;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0103);
        tick(1'b0, 1'b0, 32'h0);
        check("drop_addr", imem_addr, 32'h0);
        check("drop_valid", 32'(if_valid), 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0);

        // redirect coinciding with an ack
        do_reset();
        lat_cfg = 1;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h0000_0200);
        check("ar_valid", 32'(if_valid), 32'h1);
        tick(1'b0, 1'b0, 32'h0);
        check("ar_addr", imem_addr, 32'h0000_0200);
        check("ar_empty", 32'(if_valid), 32'h0);

        // PC wrap at the top of the address space
        lat_cfg = 0;
        tick(1'b0, 1'b1, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0);
        check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        tick(1'b0, 1'b0, 32'h0);
        check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        check("wrap_a2", imem_addr, 32'h0);
        check("wrap_pc4", if_pc_plus4, 32'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);

        // reset while a fetch is outstanding
        do_reset();
        lat_cfg = 0;
        tick(1'b1, 1'b0, 32'h0);
        lat_cfg = 5;
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        check("wait_req", 32'(imem_req), 32'h1);
        check("wait_valid", 32'(if_valid), 32'h1);
        do_reset();

        // random stall / redirect / latency mix
        lat_cfg = -1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
